// File: rtl/mbt_lookup_pipe.sv
// rtl/mbt_lookup_pipe.sv - parametrised multi-lane MBitTree lookup pipeline
//
// NUM_PORTS lanes walk a LEVELS-deep decision tree, one level per enabled
// cycle, and emit the reached node with the original header after exactly
// LEVELS enabled cycles.
//
// Optional feature macro: MBT_STATS_EN (per-lane lookup/hit counters).
//
// Ports:
//   clk            clock, rising edge
//   RSTn           asynchronous active-low reset
//   packet_in      lane i header at [i*PACKET_WIDTH +: PACKET_WIDTH]
//   data_valid_in  per-lane input valid
//   pipe_en        1 = advance, 0 = hold all stage/read/output registers
//   cfg_we         node memory write strobe (independent of pipe_en)
//   cfg_level      target level memory (>= LEVELS ignored)
//   cfg_addr       target address
//   cfg_data       node word
//   packet_out     header after the walk
//   node_out       final node per lane
//   data_valid_out per-lane output valid
//   leaf_hit       data_valid_out & node bit 0
//   stats_clr      synchronous counter clear (MBT_STATS_EN only)
//   lookup_cnt     per-lane completed lookups, 32 bits each
//   hit_cnt        per-lane lookups ending on a leaf, 32 bits each
module mbt_lookup_pipe #(
  parameter int NUM_PORTS    = 2,
  parameter int LEVELS       = 4,
  parameter int PACKET_WIDTH = 104,
  parameter int NODE_WIDTH   = 40,
  parameter int NODE_ADDR    = 9,
  parameter int LVL_W        = 3
) (
  input  logic                              clk,
  input  logic                              RSTn,
  input  logic [NUM_PORTS*PACKET_WIDTH-1:0] packet_in,
  input  logic [NUM_PORTS-1:0]              data_valid_in,
  input  logic                              pipe_en,
  input  logic                              cfg_we,
  input  logic [LVL_W-1:0]                  cfg_level,
  input  logic [NODE_ADDR-1:0]              cfg_addr,
  input  logic [NODE_WIDTH-1:0]             cfg_data,
  output logic [NUM_PORTS*PACKET_WIDTH-1:0] packet_out,
  output logic [NUM_PORTS*NODE_WIDTH-1:0]   node_out,
  output logic [NUM_PORTS-1:0]              data_valid_out,
  output logic [NUM_PORTS-1:0]              leaf_hit,
  input  logic                              stats_clr,
  output logic [NUM_PORTS*32-1:0]           lookup_cnt,
  output logic [NUM_PORTS*32-1:0]           hit_cnt
);

  localparam int DEPTH = 1 << NODE_ADDR;

  // One memory per level; every lane reads it combinationally into its own
  // stage register, so each level effectively has NUM_PORTS read ports.
  logic [NODE_WIDTH-1:0] mem [LEVELS][DEPTH];

  logic [PACKET_WIDTH-1:0] st_pkt  [LEVELS][NUM_PORTS];
  logic [NODE_WIDTH-1:0]   st_node [LEVELS][NUM_PORTS];
  logic [NUM_PORTS-1:0]    st_vld  [LEVELS];

  // Writes land at the edge; reads in the same cycle see the old word because
  // stage registers sample the array before the non-blocking update.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LEVELS; l++) begin
      if (cfg_we && (cfg_level == LVL_W'(l))) begin
        mem[l][cfg_addr] <= cfg_data;
      end
    end
  end

  // Child address: bit j of the offset is packet[pos_j] when mask bit j is
  // set. Shifting right by pos yields 0 for pos >= PACKET_WIDTH, which gives
  // the out-of-range-reads-as-zero behaviour without a separate compare.
  function automatic logic [NODE_ADDR-1:0] child_addr(
    input logic [NODE_WIDTH-1:0]   node,
    input logic [PACKET_WIDTH-1:0] pkt
  );
    logic [2:0]              off;
    logic [PACKET_WIDTH-1:0] sh;
    off = '0;
    for (int j = 0; j < 3; j++) begin
      sh     = pkt >> node[7+8*j +: 8];
      off[j] = node[4+j] & sh[0];
    end
    return node[NODE_ADDR+30:31] + NODE_ADDR'(off);
  endfunction

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int k = 0; k < LEVELS; k++) begin
        st_vld[k] <= '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
          st_pkt[k][i]  <= '0;
          st_node[k][i] <= '0;
        end
      end
      packet_out     <= '0;
      node_out       <= '0;
      data_valid_out <= '0;
      leaf_hit       <= '0;
    end else if (pipe_en) begin
      st_vld[0] <= data_valid_in;
      for (int i = 0; i < NUM_PORTS; i++) begin
        st_pkt[0][i]  <= packet_in[i*PACKET_WIDTH +: PACKET_WIDTH];
        st_node[0][i] <= mem[0][0];
      end
      for (int k = 1; k < LEVELS; k++) begin
        st_vld[k] <= st_vld[k-1];
        for (int i = 0; i < NUM_PORTS; i++) begin
          st_pkt[k][i] <= st_pkt[k-1][i];
          // A leaf rides through untouched so latency stays fixed.
          if (st_node[k-1][i][0]) begin
            st_node[k][i] <= st_node[k-1][i];
          end else begin
            st_node[k][i] <= mem[k][child_addr(st_node[k-1][i], st_pkt[k-1][i])];
          end
        end
      end
      data_valid_out <= st_vld[LEVELS-1];
      for (int i = 0; i < NUM_PORTS; i++) begin
        packet_out[i*PACKET_WIDTH +: PACKET_WIDTH] <= st_pkt[LEVELS-1][i];
        node_out[i*NODE_WIDTH +: NODE_WIDTH]       <= st_node[LEVELS-1][i];
        leaf_hit[i] <= st_vld[LEVELS-1][i] & st_node[LEVELS-1][i][0];
      end
    end
  end

`ifdef MBT_STATS_EN
  logic [31:0] lcnt [NUM_PORTS];
  logic [31:0] hcnt [NUM_PORTS];

  // Counting the registered outputs on enabled edges: each output slot is
  // present for exactly one enabled cycle, so stalls never double-count.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        lcnt[i] <= '0;
        hcnt[i] <= '0;
      end
    end else if (stats_clr) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        lcnt[i] <= '0;
        hcnt[i] <= '0;
      end
    end else if (pipe_en) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (data_valid_out[i] && (lcnt[i] != 32'hFFFF_FFFF)) begin
          lcnt[i] <= lcnt[i] + 32'd1;
        end
        if (leaf_hit[i] && (hcnt[i] != 32'hFFFF_FFFF)) begin
          hcnt[i] <= hcnt[i] + 32'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign lookup_cnt[g*32 +: 32] = lcnt[g];
    assign hit_cnt[g*32 +: 32]    = hcnt[g];
  end
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign lookup_cnt       = '0;
  assign hit_cnt          = '0;
`endif

endmodule

// File: tb/tb_mbt_lookup_pipe.sv
// tb/tb_mbt_lookup_pipe.sv - scoreboard bench for mbt_lookup_pipe
module tb_mbt_lookup_pipe;
  localparam int NP = 2;
  localparam int L  = 4;
  localparam int PW = 104;
  localparam int NW = 40;
  localparam int NA = 9;
  localparam int LW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              RSTn;
  logic [NP*PW-1:0]  packet_in;
  logic [NP-1:0]     data_valid_in;
  logic              pipe_en;
  logic              cfg_we;
  logic [LW-1:0]     cfg_level;
  logic [NA-1:0]     cfg_addr;
  logic [NW-1:0]     cfg_data;
  logic [NP*PW-1:0]  packet_out;
  logic [NP*NW-1:0]  node_out;
  logic [NP-1:0]     data_valid_out;
  logic [NP-1:0]     leaf_hit;
  logic              stats_clr;
  logic [NP*32-1:0]  lookup_cnt;
  logic [NP*32-1:0]  hit_cnt;

  mbt_lookup_pipe #(
    .NUM_PORTS(NP), .LEVELS(L), .PACKET_WIDTH(PW),
    .NODE_WIDTH(NW), .NODE_ADDR(NA), .LVL_W(LW)
  ) dut (
    .clk(clk), .RSTn(RSTn), .packet_in(packet_in), .data_valid_in(data_valid_in),
    .pipe_en(pipe_en), .cfg_we(cfg_we), .cfg_level(cfg_level), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .packet_out(packet_out), .node_out(node_out),
    .data_valid_out(data_valid_out), .leaf_hit(leaf_hit), .stats_clr(stats_clr),
    .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference tree: plain arrays walked with integer arithmetic.
  logic [NW-1:0] mm [L][1<<NA];

  function automatic logic [NW-1:0] walk(input logic [PW-1:0] pk);
    logic [NW-1:0] n;
    int base, off, pos;
    n = mm[0][0];
    for (int k = 1; k < L; k++) begin
      if (n[0] == 1'b0) begin
        base = int'(n[NA+30:31]);
        off  = 0;
        for (int j = 0; j < 3; j++) begin
          pos = int'(n[7+8*j +: 8]);
          if (n[4+j] && pos < PW && pk[pos]) off += (1 << j);
        end
        n = mm[k][(base + off) % (1 << NA)];
      end
    end
    return n;
  endfunction

  function automatic logic [PW-1:0] rnd_pkt();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] pk5(input logic b);
    logic [PW-1:0] r;
    r    = rnd_pkt();
    r[5] = b;
    return r;
  endfunction

  function automatic logic [NW-1:0] rnd_node();
    logic [63:0]   r;
    logic [NW-1:0] n;
    r = {$urandom, $urandom};
    n = r[NW-1:0];
    if ($urandom_range(0, 2) == 0) begin
      n[0] = 1'b1;
    end else begin
      n[0]     = 1'b0;
      n[14:7]  = 8'($urandom_range(0, 127));
      n[22:15] = 8'($urandom_range(0, 127));
      n[30:23] = 8'($urandom_range(0, 127));
    end
    return n;
  endfunction

  function automatic logic [NW-1:0] inode(input logic [2:0] m, input int p0, input int base);
    logic [NW-1:0] n;
    n        = '0;
    n[6:4]   = m;
    n[14:7]  = 8'(p0);
    n[NA+30:31] = NA'(base);
    return n;
  endfunction

  typedef struct {
    logic [PW-1:0] pkt;
    logic [NW-1:0] node;
    int            due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ecnt = 0;
  int   exp_lk[NP];
  int   exp_hit[NP];

  always @(posedge clk) if (RSTn && pipe_en) ecnt++;

  task automatic drive(input logic en, input logic [1:0] v, input logic [PW-1:0] p0,
                       input logic [PW-1:0] p1, input logic we, input logic [LW-1:0] lvl,
                       input logic [NA-1:0] ad, input logic [NW-1:0] dat, input logic clr);
    exp_t e;
    pipe_en       = en;
    data_valid_in = v;
    packet_in     = {p1, p0};
    cfg_we        = we;
    cfg_level     = lvl;
    cfg_addr      = ad;
    cfg_data      = dat;
    stats_clr     = clr;
    if (en) begin
      for (int i = 0; i < NP; i++) begin
        if (v[i]) begin
          e.pkt  = (i == 0) ? p0 : p1;
          e.node = walk(e.pkt);
          e.due  = ecnt + 1 + L;
          exp_lk[i]++;
          if (e.node[0]) exp_hit[i]++;
          if (i == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
      end
    end
    if (we && lvl < L) mm[lvl][ad] = dat;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 2'b00, '0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic wr(input int lvl, input int ad, input logic [NW-1:0] dat);
    drive(1'b1, 2'b00, '0, '0, 1'b1, LW'(lvl), NA'(ad), dat, 1'b0);
  endtask

  task automatic chk_zero_out(input string tag);
    chk({tag, "_valid"}, data_valid_out, 0);
    chk({tag, "_leaf"},  leaf_hit, 0);
    chk({tag, "_pkt0"},  packet_out[PW-1:0], 0);
    chk({tag, "_node"},  node_out, 0);
  endtask

  // Monitor: after every enabled edge, pop and compare each valid lane.
  int last_e = 0;
  always @(negedge clk) begin
    exp_t e;
    if (ecnt != last_e) begin
      last_e = ecnt;
      for (int i = 0; i < NP; i++) begin
        if (data_valid_out[i]) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_valid lane %0d: got valid, expected none", i);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("pkt%0d", i), packet_out[i*PW +: PW], e.pkt);
            chk($sformatf("node%0d", i), node_out[i*NW +: NW], e.node);
            chk($sformatf("leaf%0d", i), leaf_hit[i], e.node[0]);
            chk($sformatf("latency%0d", i), ecnt, e.due);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW-1:0] leaf_a, leaf_b, leaf_c;
    logic          seen;
    RSTn = 1'b0;
    pipe_en = 1'b0; data_valid_in = '0; packet_in = '0; cfg_we = 1'b0;
    cfg_level = '0; cfg_addr = '0; cfg_data = '0; stats_clr = 1'b0;
    exp_lk = '{default: 0};
    exp_hit = '{default: 0};
    repeat (3) @(negedge clk);
    chk_zero_out("reset");
    chk("reset_lookup_cnt", lookup_cnt, 0);
    chk("reset_hit_cnt", hit_cnt, 0);
    RSTn = 1'b1;
    @(negedge clk);

    // Fill every level with random nodes; pipe_en toggles to show writes
    // do not depend on it.
    for (int l = 0; l < L; l++)
      for (int a = 0; a < (1 << NA); a++)
        drive(1'($urandom_range(0, 1)), 2'b00, '0, '0, 1'b1, LW'(l), NA'(a), rnd_node(), 1'b0);

    // Random traffic with random stalls and writes to nonexistent levels.
    repeat (400) begin
      drive(1'($urandom_range(0, 4) != 0), 2'($urandom), rnd_pkt(), rnd_pkt(),
            1'($urandom), LW'($urandom_range(L, 7)),
            ($urandom_range(0, 1) != 0) ? NA'(0) : NA'($urandom), rnd_node(), 1'b0);
    end
    idle(L + 2);

    // Directed tree: root tests bit 5; L1[9] leaf, L1[8] -> L2[3] leaf.
    leaf_a = rnd_node(); leaf_a[0] = 1'b1;
    leaf_b = rnd_node(); leaf_b[0] = 1'b1;
    leaf_c = rnd_node(); leaf_c[0] = 1'b1;
    wr(0, 0, inode(3'b001, 5, 8));
    wr(1, 9, leaf_a);
    wr(1, 8, inode(3'b000, 0, 3));
    wr(2, 3, leaf_b);

    drive(1'b1, 2'b01, pk5(1'b1), '0, 1'b0, '0, '0, '0, 1'b0);   // single lookup
    idle(L + 2);
    drive(1'b1, 2'b11, pk5(1'b0), pk5(1'b1), 1'b0, '0, '0, '0, 1'b0);   // divergence
    idle(L + 2);

    // Stall mid-flight; inputs presented during the stall must be ignored.
    repeat (3) drive(1'b1, 2'b11, rnd_pkt(), rnd_pkt(), 1'b0, '0, '0, '0, 1'b0);
    repeat (3) drive(1'b0, 2'b11, rnd_pkt(), rnd_pkt(), 1'b0, '0, '0, '0, 1'b0);
    idle(L + 2);

    // Collision: write L1[9] in the cycle stage 1 reads it.
    drive(1'b1, 2'b01, pk5(1'b1), '0, 1'b0, '0, '0, '0, 1'b0);
    drive(1'b1, 2'b00, '0, '0, 1'b1, 3'd1, 9'd9, leaf_c, 1'b0);
    drive(1'b1, 2'b01, pk5(1'b1), '0, 1'b0, '0, '0, '0, 1'b0);
    idle(L + 2);

    // Miss tree: a chain of internal nodes that never reaches a leaf.
    wr(0, 0, inode(3'b000, 0, 20));
    wr(1, 20, inode(3'b000, 0, 20));
    wr(2, 20, inode(3'b000, 0, 20));
    wr(3, 20, inode(3'b000, 0, 20));
    repeat (5) drive(1'b1, 2'b11, rnd_pkt(), rnd_pkt(), 1'b0, '0, '0, '0, 1'b0);
    idle(L + 2);

    // Reset with lookups in flight and an output currently valid.
    repeat (5) drive(1'b1, 2'b11, rnd_pkt(), rnd_pkt(), 1'b0, '0, '0, '0, 1'b0);
    #2 RSTn = 1'b0;
    #1 chk_zero_out("midreset");
    q0.delete();
    q1.delete();
    @(negedge clk);
    RSTn = 1'b1;
    idle(L + 2);

    // Stats: bit5=1 hits L1[9]; bit5=0 ends on an internal L3 node.
    wr(0, 0, inode(3'b001, 5, 8));
    wr(2, 3, inode(3'b000, 0, 0));
    wr(3, 0, inode(3'b000, 0, 0));
    drive(1'b1, 2'b00, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    exp_lk = '{default: 0};
    exp_hit = '{default: 0};
    for (int n = 0; n < 10; n++)
      drive(1'b1, {1'b1, 1'($urandom)}, rnd_pkt(), pk5(1'((n % 5) < 3)), 1'b0, '0, '0, '0, 1'b0);
    idle(L + 2);
`ifdef MBT_STATS_EN
    chk("lookup_cnt0", lookup_cnt[31:0], exp_lk[0]);
    chk("lookup_cnt1", lookup_cnt[63:32], exp_lk[1]);
    chk("hit_cnt0", hit_cnt[31:0], exp_hit[0]);
    chk("hit_cnt1", hit_cnt[63:32], exp_hit[1]);
`else
    chk("lookup_cnt_tied", lookup_cnt, 0);
    chk("hit_cnt_tied", hit_cnt, 0);
`endif

    // Clear concurrent with a valid output on lane 1.
    drive(1'b1, 2'b10, '0, pk5(1'b1), 1'b0, '0, '0, '0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (data_valid_out[1]) seen = 1'b1;
      else idle(1);
    end
    chk("clr_output_seen", seen, 1);
    drive(1'b1, 2'b00, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    chk("clr_lookup_cnt", lookup_cnt, 0);
    chk("clr_hit_cnt", hit_cnt, 0);
    idle(L + 2);

    chk("scoreboard_empty", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mbt_lookup_pipe.md
# mbt_lookup_pipe

Parametrised MBitTree lookup pipeline: NUM_PORTS independent lanes walk a LEVELS-deep decision tree held in per-level node memories, one level per cycle, and deliver the reached leaf node together with the packet header. It replaces the fixed dual-port, fixed-depth, ROM-backed tree stages. It sits between packet ingress and rule matching. It adds three capabilities the fixed stages lack:
- a runtime node-update port
- a global pipeline stall
- optional per-lane statistics

## Interface
- NUM_PORTS, 2, number of parallel lookup lanes
- LEVELS, 4, tree depth; one memory and one pipeline stage per level (≥1)
- PACKET_WIDTH, 104, header width per lane
- NODE_WIDTH, 40, node word width
- NODE_ADDR, 9, address width of every level memory (depth 2^NODE_ADDR)
- LVL_W, 3, width of cfg_level

Ports:
- clk  in  1  clock; all logic on rising edge
- RSTn  in  1  asynchronous active-low reset
- packet_in  in  NUM_PORTS*PACKET_WIDTH  lane i header at [i*PACKET_WIDTH +: PACKET_WIDTH]
- data_valid_in  in  NUM_PORTS  per-lane input valid
- pipe_en  in  1  1 = pipeline advances; 0 = all stage registers hold
- cfg_we  in  1  node memory write strobe
- cfg_level  in  LVL_W  target level memory
- cfg_addr  in  NODE_ADDR  target address
- cfg_data  in  NODE_WIDTH  node word
- packet_out  out  NUM_PORTS*PACKET_WIDTH  header after tree walk
- node_out  out  NUM_PORTS*NODE_WIDTH  final node per lane
- data_valid_out  out  NUM_PORTS  per-lane output valid
- leaf_hit  out  NUM_PORTS  output node is a leaf (data_valid_out & node bit 0)
- stats_clr  in  1  clears counters (MBT_STATS_EN only)
- lookup_cnt  out  NUM_PORTS*32  per-lane lookups completed
- hit_cnt  out  NUM_PORTS*32  per-lane lookups ending on a leaf

## Operation
Internal node format:
- [0] type, 0 = internal
- [3:1] level
- [6:4] mask m2..m0
- [14:7] pos0, [22:15] pos1, [30:23] pos2
- [NODE_ADDR+30:31] baseAddr

Leaf format: [0] = 1. The remaining leaf bits are opaque and are carried unchanged.

Child computation:
- offset[j] = m[j] ? packet[pos_j] : 0, for j = 0..2
- Any pos_j ≥ PACKET_WIDTH reads as 0.
- child address = (baseAddr + offset) mod 2^NODE_ADDR.

Stages:
- Stage 0: latches the header and valid, and reads level-0 memory at address 0 (the root).
- Stage k (1..LEVELS-1), when its input node is internal: reads level-k memory at the child address.
- Stage k, when its input node is a leaf: passes the node through unchanged and performs no memory read.

Node-level rules:
- The node level field is not checked.
- A lookup that is still internal after the last stage exits with leaf_hit = 0.

Lane independence:
- Lanes are fully independent and share contents, not timing.
- Each level memory provides NUM_PORTS read ports and one write port.

Configuration writes:
- When cfg_we = 1 and cfg_level < LEVELS, the write takes effect at the clock edge, regardless of pipe_en.
- When cfg_level ≥ LEVELS, the write is ignored.
- A read and a write to the same level/address in the same cycle return the old data (read-first).

Stall: while pipe_en = 0, stage registers, memory read registers and outputs hold, and inputs are ignored.

Reset:
- The following clear to 0 asynchronously: all valids, packet_out, node_out, leaf_hit, and the counters.
- Memory contents are not reset.
- Lookups in flight are discarded. The first output after reset release is valid only for inputs applied after release.

## Timing
- Latency is exactly LEVELS enabled cycles: an input sampled at edge t with pipe_en = 1 throughout appears at edge t+LEVELS.
- Throughput is one lookup per lane per enabled cycle; there are no bubbles.
- Leaf early exit does not shorten latency.
- Each pipe_en = 0 cycle adds one cycle of latency to every in-flight lookup. Ordering is preserved.
- An invalid slot (data_valid_in = 0) still propagates. Its node and packet contents are don't-care but registered.

## Configuration
- MBT_STATS_EN defined:
  - Per lane, lookup_cnt increments on every enabled cycle with data_valid_out = 1.
  - hit_cnt increments when leaf_hit = 1 as well.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
  - stats_clr zeroes them synchronously and takes priority over increment.
- MBT_STATS_EN undefined: the counter ports remain, tied to 0, and stats_clr is ignored. No counter logic is generated.

## Test plan
- **Single lookup:** LEVELS=4; program root at L0[0] with mask=001, pos0=5, base=8, and program L1[9] as a leaf (0x...1). Send packet bit5 = 1 on lane 0 → 4 cycles later data_valid_out[0] = 1, leaf_hit[0] = 1, node_out = L1[9], packet echoed.
- **Dual-lane divergence:** same tree with L1[8] internal leading to an L2 leaf. Lane 0 has bit5 = 0 and lane 1 has bit5 = 1, sent in the same cycle → both outputs at +4; each node_out equals the node on its own path.
- **Stall:** back-to-back packets A, B, C with pipe_en held low for 3 cycles mid-flight → A, B, C still emerge in order, each with latency 4+3, with no loss or duplication.
- **Config collision:** write a new leaf to L1[9] in the cycle that stage 1 reads L1[9] → that lookup returns the old node; the next packet returns the new one.
- **Reset and miss:** assert RSTn low for 1 cycle with 3 lookups in flight → all outputs 0 immediately. A tree with no leaves within 4 levels → leaf_hit = 0 while data_valid_out = 1.
- **Stats (MBT_STATS_EN):** 10 lookups with 6 hits on lane 1 → lookup_cnt[1] = 10, hit_cnt[1] = 6. stats_clr asserted concurrently with a valid output → counters read 0 after that edge.
